addmul_op_scheduler: RTL and testbench
======================================

// Module: addmul_op_scheduler
// PURPOSE
//   Shares one add/multiply datapath between two requesters. Round-robin arbitrates
//   valid/ready requests, sequences a 1-cycle add or a WIDTH-cycle shift-add multiply,
//   and returns tagged results over a valid/ready response port with backpressure.
//   Sits between the tt_um_adder_multiplier pin decode and the arithmetic core.
// PARAMETERS
//   WIDTH  8  operand width in bits; result is 2*WIDTH; multiply takes WIDTH cycles
// PORTS
//   clk         in   1        single clock, rising edge
//   rst         in   1        asynchronous, active-high reset
//   req_valid   in   2        per-requester request valid
//   req_ready   out  2        per-requester accept; at most one bit high
//   req_op      in   2        per-requester op: 0=ADD, 1=MUL
//   req_a       in   2*WIDTH  operand A; requester i in [i*WIDTH +: WIDTH]
//   req_b       in   2*WIDTH  operand B; same packing
//   rsp_valid   out  1        result valid
//   rsp_ready   in   1        downstream accepts result
//   rsp_id      out  1        requester index of result
//   rsp_op      out  1        op of result
//   rsp_result  out  2*WIDTH  unsigned result
//   busy        out  1        high in any state but IDLE
//   perf_ops    out  16       completed-op count (only with ADDMUL_PERF_CNT_EN)
// BEHAVIOUR
//   Reset: state IDLE; req_ready=0, rsp_valid=0, rsp_id=0, rsp_op=0, rsp_result=0,
//     busy=0, RR pointer favours requester 0. Async: outputs clear on rst assertion.
//   FSM: IDLE -> ADD | MUL -> RESP -> IDLE.
//   - IDLE: req_ready combinational = one-hot grant of valid requesters; none valid -> 0.
//     Accept on edge with req_valid[i]&req_ready[i]; operands, op, id captured.
//   - ADD: one cycle; result = {WIDTH'b0, a} + {WIDTH'b0, b} (carry in bit WIDTH).
//   - MUL: WIDTH cycles shift-add over B LSB-first; unsigned 2*WIDTH product.
//   - RESP: rsp_valid=1; rsp_id/op/result stable until rsp_valid&rsp_ready edge -> IDLE.
//   Latency (accept edge to rsp_valid visible): ADD 2 edges, MUL WIDTH+1 edges.
//   Throughput: no accept outside IDLE; req_ready=0 in ADD/MUL/RESP.
//   Arbitration: both valid -> grant the one not served last; pointer updates only on
//     accept. Single valid -> granted regardless of pointer.
//   Requesters hold valid/op/operands stable until accepted; a dropped valid before
//     accept is legal and simply not granted.
//   rsp_ready low in RESP: hold indefinitely, no state change.
//   rsp_ready high outside RESP: ignored.
//   rst mid-ADD/MUL/RESP: operation discarded, no response emitted, pointer reset.
//   Extremes: a=b=0 -> 0; all-ones MUL -> (2^WIDTH-1)^2; no overflow possible.
// CONFIGURATION
//   ADDMUL_PERF_CNT_EN defined: perf_ops port present; 16-bit counter, reset 0,
//     +1 on each rsp_valid&rsp_ready edge, wraps 0xFFFF->0.
//   Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//   addmul_pkg: op encoding (OP_ADD=0, OP_MUL=1), FSM state enum
//     (ST_IDLE, ST_ADD, ST_MUL, ST_RESP), NREQ=2.
//   Sub-module addmul_rr_arb: 2-way round-robin arbiter
//     (req, accept -> one-hot grant, pointer state).
//   Datapath (accumulator, multiplicand shift reg, bit counter) inline in this module.
// TESTING (WIDTH=8)
//   1. req0 ADD a=200 b=100, rsp_ready=1 -> rsp_result=0x012C, rsp_id=0, 2 edges after accept.
//   2. req1 MUL a=255 b=255 -> rsp_result=0xFE01, rsp_id=1, 9 edges after accept; busy high throughout.
//   3. After reset both valid ADD 1+1 -> req0 served first, then req1; repeat both -> req0 then req1 again.
//   4. MUL 12*13 with rsp_ready=0 for 5 cycles in RESP -> result 0x009C held, req_ready=0, then IDLE.
//   5. rst pulse 3 cycles into MUL 7*9 -> rsp_valid never rises; next ADD 3+4 returns 0x0007.
//   6. With ADDMUL_PERF_CNT_EN: 3 completed ops -> perf_ops=3; rst -> perf_ops=0.

Source files
------------

// File: rtl/addmul_pkg.sv
// rtl/addmul_pkg.sv - shared op encoding, FSM states and requester count
// for the add/multiply scheduler.
package addmul_pkg;
  localparam int NREQ = 2;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADD,
    ST_MUL,
    ST_RESP
  } state_e;
endpackage

// File: rtl/addmul_rr_arb.sv
// rtl/addmul_rr_arb.sv - 2-way round-robin arbiter; one-hot grant while enabled,
// priority pointer moves only when a grant is taken.
import addmul_pkg::*;

module addmul_rr_arb (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            accept
);
  // r_prio names the requester that wins a tie; 0 after reset.
  logic r_prio;

  always_comb begin
    grant = '0;
    if (en) begin
      if (&req) grant = r_prio ? 2'b10 : 2'b01;
      else      grant = req;
    end
  end

  assign accept = |grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_prio <= 1'b0;
    else if (accept) r_prio <= grant[0];
  end
endmodule

// File: rtl/addmul_op_scheduler.sv
// rtl/addmul_op_scheduler.sv - arbitrates two requesters onto one add / shift-add multiply
// datapath with a backpressured tagged response; ADDMUL_PERF_CNT_EN adds perf_ops.
import addmul_pkg::*;

module addmul_op_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_op,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic                    rsp_op,
  output logic [2*WIDTH-1:0]      rsp_result,
  output logic                    busy
`ifdef ADDMUL_PERF_CNT_EN
  ,
  output logic [15:0]             perf_ops
`endif
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e               r_state, w_next;
  logic [NREQ-1:0]      w_grant;
  logic                 w_accept;
  logic                 w_sel;
  logic [WIDTH-1:0]     w_a, w_b;
  logic [2*WIDTH-1:0]   r_acc, r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [CW-1:0]        r_cnt;
  logic                 r_id, r_op;

  addmul_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (r_state == ST_IDLE),
    .req    (req_valid),
    .grant  (w_grant),
    .accept (w_accept)
  );

  assign req_ready = w_grant;
  assign w_sel     = w_grant[1];
  assign w_a       = w_sel ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
  assign w_b       = w_sel ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = (req_op[w_sel] == OP_MUL) ? ST_MUL : ST_ADD;
      ST_ADD:  w_next = ST_RESP;
      ST_MUL:  if (r_cnt == LAST) w_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // A lives zero-extended in r_mcand and B in r_mplier; ADD reuses the same registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_id     <= 1'b0;
      r_op     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_acc    <= '0;
          r_mcand  <= {{WIDTH{1'b0}}, w_a};
          r_mplier <= w_b;
          r_cnt    <= '0;
          r_id     <= w_sel;
          r_op     <= req_op[w_sel];
        end
        ST_ADD: r_acc <= r_mcand + {{WIDTH{1'b0}}, r_mplier};
        ST_MUL: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid  = (r_state == ST_RESP);
  assign busy       = (r_state != ST_IDLE);
  assign rsp_result = r_acc;
  assign rsp_id     = r_id;
  assign rsp_op     = r_op;

`ifdef ADDMUL_PERF_CNT_EN
  logic [15:0] r_perf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_perf <= '0;
    else if (rsp_valid && rsp_ready) r_perf <= r_perf + 16'd1;
  end
  assign perf_ops = r_perf;
`endif
endmodule

// File: tb/tb_addmul_op_scheduler.sv
// tb/tb_addmul_op_scheduler.sv - scoreboard bench for addmul_op_scheduler (WIDTH=8);
// define ADDMUL_PERF_CNT_EN to also cover perf_ops.
module tb_addmul_op_scheduler;
  localparam int W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid, req_ready, req_op;
  logic [2*W-1:0]  req_a, req_b;
  logic            rsp_valid, rsp_ready, rsp_id, rsp_op, busy;
  logic [2*W-1:0]  rsp_result;
`ifdef ADDMUL_PERF_CNT_EN
  logic [15:0]     perf_ops;
`endif

  addmul_op_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_op(rsp_op), .rsp_result(rsp_result), .busy(busy)
`ifdef ADDMUL_PERF_CNT_EN
    , .perf_ops(perf_ops)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; int op; int res; } exp_t;
  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input int op, input int res);
    exp_t e;
    e.id = id; e.op = op; e.res = res;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rsp_id", int'(rsp_id), e.id);
        check("rsp_op", int'(rsp_op), e.op);
        check("rsp_result", int'(rsp_result), e.res);
      end
    end
  end

  // Holds the request until granted; ae = index of the accepting clock edge.
  task automatic issue(input int id, input int op, input int a, input int b, output int ae);
    @(posedge clk); #1;
    req_valid[id] = 1'b1;
    req_op[id] = op[0];
    req_a[id*W +: W] = a[W-1:0];
    req_b[id*W +: W] = b[W-1:0];
    ae = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin ae = cyc + 1; break; end
    end
    if (ae < 0) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(output int re, output int busy_low);
    re = -1;
    busy_low = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rsp_valid) begin re = cyc; break; end
      if (!busy) busy_low++;
    end
    if (re < 0) check("rsp_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge clk);
    check("sb_drained", q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  int ae, re, bl, served, g, seen;

  initial begin
    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_id", int'(rsp_id), 0);
    check("rst_rsp_op", int'(rsp_op), 0);
    check("rst_rsp_result", int'(rsp_result), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk); #1 rst = 1'b0;

    push(0, 0, 'h012C);
    issue(0, 0, 200, 100, ae);
    wait_rsp(re, bl);
    check("t1_latency", re - ae + 1, 2);

    push(1, 1, 'hFE01);
    issue(1, 1, 255, 255, ae);
    wait_rsp(re, bl);
    check("t2_latency", re - ae + 1, W + 1);
    check("t2_busy_low", bl, 0);
    drain();

    do_reset();
    for (int r = 0; r < 2; r++) begin
      push(0, 0, 2);
      push(1, 0, 2);
    end
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      req_valid = 2'b11; req_op = 2'b00; req_a = {8'd1, 8'd1}; req_b = {8'd1, 8'd1};
      served = 0;
      for (int k = 0; k < 40 && served < 2; k++) begin
        @(negedge clk);
        if (|req_ready) begin
          g = int'(req_ready[1]);
          check("t3_grant_order", g, served);
          check("t3_onehot", int'($countones(req_ready)), 1);
          @(posedge clk); #1;
          req_valid[g] = 1'b0;
          served++;
        end
      end
      check("t3_served", served, 2);
    end
    drain();

    rsp_ready = 1'b0;
    push(0, 1, 'h009C);
    issue(0, 1, 12, 13, ae);
    wait_rsp(re, bl);
    check("t4_latency", re - ae + 1, W + 1);
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_op[1] = 1'b0; req_a[W +: W] = 8'd5; req_b[W +: W] = 8'd6;
    push(1, 0, 11);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_hold_valid", int'(rsp_valid), 1);
      check("t4_hold_result", int'(rsp_result), 'h009C);
      check("t4_req_ready", int'(req_ready), 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    g = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[1]) begin g = 1; break; end
    end
    check("t4_req1_granted", g, 1);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    wait_rsp(re, bl);
    drain();

    issue(0, 1, 7, 9, ae);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    check("t5_async_busy", int'(busy), 0);
    check("t5_async_valid", int'(rsp_valid), 0);
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("t5_no_rsp", seen, 0);
    push(0, 0, 7);
    issue(0, 0, 3, 4, ae);
    wait_rsp(re, bl);
    check("t5_latency", re - ae + 1, 2);
    drain();

    push(0, 0, 0);
    issue(0, 0, 0, 0, ae);
    wait_rsp(re, bl);
    push(1, 1, 0);
    issue(1, 1, 0, 0, ae);
    wait_rsp(re, bl);
    push(1, 0, 'h01FE);
    issue(1, 0, 255, 255, ae);
    wait_rsp(re, bl);
    push(0, 1, 'h00FF);
    issue(0, 1, 1, 255, ae);
    wait_rsp(re, bl);
    drain();

`ifdef ADDMUL_PERF_CNT_EN
    do_reset();
    push(0, 0, 3);
    issue(0, 0, 1, 2, ae);
    wait_rsp(re, bl);
    push(1, 0, 30);
    issue(1, 0, 10, 20, ae);
    wait_rsp(re, bl);
    push(0, 1, 15);
    issue(0, 1, 3, 5, ae);
    wait_rsp(re, bl);
    drain();
    @(negedge clk);
    check("t6_perf_ops", int'(perf_ops), 3);
    @(posedge clk); #1 rst = 1'b1;
    #2;
    check("t6_perf_rst", int'(perf_ops), 0);
    @(posedge clk); #1 rst = 1'b0;
`endif

    check("sb_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
